fixed_weight_word_generator: RTL and testbench

//   Inverse companion to the population counter: takes a Hamming weight k and

---
 rtl/fixed_weight_word_generator.sv | 127 ++++++++++++
 tb/tb_fixed_weight_word_generator.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fixed_weight_word_generator.sv
// Emits every BITS-wide word of popcount k, ascending, one per handshake.
// Ports: start/weight in, out_* stream, busy/done/err status; FWG_WORD_INDEX_EN adds word_idx.
module fixed_weight_word_generator #(
  parameter  int BITS = 4,
  localparam int CW   = $clog2(BITS) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [CW-1:0]   weight,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out_word,
  output logic            out_last,
`ifdef FWG_WORD_INDEX_EN
  output logic [BITS-1:0] word_idx,
`endif
  output logic            done,
  output logic            err
);

  localparam int WW = BITS + 1;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    FIN
  } state_t;

  state_t          state;
  logic [BITS-1:0] last_q;

  logic [WW-1:0]   x, c, r, ones, fm;
  logic [CW-1:0]   tz;
  logic [BITS-1:0] nxt, first_w, last_w;
  logic            accept;
  logic            unused_ok;

  assign accept = out_valid && out_ready;

  // Next word with the same popcount: add the lowest set bit to carry
  // the lowest run of ones upward, then refill the low end with the
  // run's remaining ones (shifted down by tz+2 instead of dividing).
  always_comb begin
    tz = '0;
    for (int i = BITS - 1; i >= 0; i--) begin
      if (out_word[i]) tz = CW'(i);
    end
    x    = {1'b0, out_word};
    c    = x & (~x + WW'(1));
    r    = x + c;
    ones = ((x ^ r) >> tz) >> 2;
    nxt  = r[BITS-1:0] | ones[BITS-1:0];
  end

  // First word is k low ones; last word is the same run at the top.
  always_comb begin
    fm      = (WW'(1) << weight) - WW'(1);
    first_w = fm[BITS-1:0];
    last_w  = BITS'(fm << (BITS - int'(weight)));
  end

  assign unused_ok = ^{r[BITS], ones[BITS], fm[BITS]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_word  <= '0;
      out_last  <= 1'b0;
      last_q    <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef FWG_WORD_INDEX_EN
      word_idx  <= '0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (int'(weight) > BITS) begin
              err <= 1'b1;
            end else begin
              state     <= EMIT;
              busy      <= 1'b1;
              out_valid <= 1'b1;
              out_word  <= first_w;
              out_last  <= (first_w == last_w);
              last_q    <= last_w;
`ifdef FWG_WORD_INDEX_EN
              word_idx  <= '0;
`endif
            end
          end
        end
        EMIT: begin
          if (accept) begin
`ifdef FWG_WORD_INDEX_EN
            word_idx <= word_idx + BITS'(1);
`endif
            if (out_last) begin
              state     <= FIN;
              busy      <= 1'b0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
            end else begin
              out_word <= nxt;
              out_last <= (nxt == last_q);
            end
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_weight_word_generator.sv
// Directed bench for fixed_weight_word_generator (BITS=4).
// Checks sequences, stalls, ignored starts, bad weight and async reset.
module tb_fixed_weight_word_generator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] weight;
  logic       busy;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_word;
  logic       out_last;
  logic       done;
  logic       err;
`ifdef FWG_WORD_INDEX_EN
  logic [3:0] word_idx;
`endif

  int tests = 0;
  int fails = 0;

  fixed_weight_word_generator #(.BITS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .weight    (weight),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_last  (out_last),
`ifdef FWG_WORD_INDEX_EN
    .word_idx  (word_idx),
`endif
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // valid, word, last, busy, done, err
  task automatic chk_all(input string tag, input logic v,
                         input logic [3:0] w, input logic l,
                         input logic b, input logic d, input logic e);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".word"},  32'(out_word),  32'(w));
    chk({tag, ".last"},  32'(out_last),  32'(l));
    chk({tag, ".busy"},  32'(busy),      32'(b));
    chk({tag, ".done"},  32'(done),      32'(d));
    chk({tag, ".err"},   32'(err),       32'(e));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [2:0] k);
    start  = 1'b1;
    weight = k;
    tick();
    start  = 1'b0;
  endtask

  logic [3:0] seq2 [6];
  logic [3:0] seq1 [4];

  initial begin
    seq2 = '{4'b0011, 4'b0101, 4'b0110, 4'b1001, 4'b1010, 4'b1100};
    seq1 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    rst_n     = 1'b0;
    start     = 1'b0;
    weight    = '0;
    out_ready = 1'b1;
    #3;
    chk_all("rst", 0, 4'b0000, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_all("idle", 0, 4'b0000, 0, 0, 0, 0);

    // k=2 free-running
    go(3'd2);
    for (int i = 0; i < 6; i++) begin
      chk_all($sformatf("k2[%0d]", i), 1, seq2[i], i == 5, 1, 0, 0);
`ifdef FWG_WORD_INDEX_EN
      chk($sformatf("k2idx[%0d]", i), 32'(word_idx), i);
`endif
      tick();
    end
    chk_all("k2fin", 0, 4'b1100, 0, 0, 1, 0);
    tick();
    chk_all("k2idle", 0, 4'b1100, 0, 0, 0, 0);

    // k=0 and k=4; start during FIN ignored
    go(3'd0);
    chk_all("k0", 1, 4'b0000, 1, 1, 0, 0);
`ifdef FWG_WORD_INDEX_EN
    chk("k0idx", 32'(word_idx), 0);
`endif
    tick();
    chk_all("k0fin", 0, 4'b0000, 0, 0, 1, 0);
    go(3'd4);
    chk_all("finstart", 0, 4'b0000, 0, 0, 0, 0);
    go(3'd4);
    chk_all("k4", 1, 4'b1111, 1, 1, 0, 0);
    tick();
    chk_all("k4fin", 0, 4'b1111, 0, 0, 1, 0);
    tick();

    // k=5 rejected
    go(3'd5);
    chk_all("k5err", 0, 4'b1111, 0, 0, 0, 1);
    tick();
    chk_all("k5idle", 0, 4'b1111, 0, 0, 0, 0);

    // stall on 0101, stray start ignored
    go(3'd2);
    chk_all("st0", 1, 4'b0011, 0, 1, 0, 0);
    tick();
    out_ready = 1'b0;
    start     = 1'b1;
    weight    = 3'd1;
    for (int i = 0; i < 3; i++) begin
      chk_all($sformatf("hold[%0d]", i), 1, 4'b0101, 0, 1, 0, 0);
      tick();
      start = 1'b0;
    end
    out_ready = 1'b1;
    chk_all("hold[3]", 1, 4'b0101, 0, 1, 0, 0);
    tick();
    for (int i = 2; i < 6; i++) begin
      chk_all($sformatf("st[%0d]", i), 1, seq2[i], i == 5, 1, 0, 0);
      tick();
    end
    chk_all("stfin", 0, 4'b1100, 0, 0, 1, 0);
    tick();

    // async reset mid-sequence
    go(3'd2);
    tick();
    tick();
    tick();
    chk_all("pre_rst", 1, 4'b1001, 0, 1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("arst", 0, 4'b0000, 0, 0, 0, 0);
`ifdef FWG_WORD_INDEX_EN
    chk("arstidx", 32'(word_idx), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    go(3'd1);
    for (int i = 0; i < 4; i++) begin
      chk_all($sformatf("k1[%0d]", i), 1, seq1[i], i == 3, 1, 0, 0);
`ifdef FWG_WORD_INDEX_EN
      chk($sformatf("k1idx[%0d]", i), 32'(word_idx), i);
`endif
      tick();
    end
    chk_all("k1fin", 0, 4'b1000, 0, 0, 1, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
